// File: rtl/cv_bus_initiator.sv
// Z80-style bus initiator: turns single-beat memory/I-O read/write commands
// into T-state sequenced mreq_n/iorq_n/rd_n/wr_n cycles, appends refresh
// cycles after memory accesses and aborts on a wait_n timeout.
//
// state | meaning
// IDLE  | waiting for a command, strobes released
// T1    | address phase
// T2    | strobe phase, wait_n sampled on its last clock (memory)
// TW    | wait state, wait_n sampled on its last clock
// T3    | data phase, read data captured on its last clock
// R1    | refresh address phase (rfsh_n low)
// R2    | refresh strobe phase (rfsh_n and mreq_n low)
module cv_bus_initiator #(
   parameter int T_DIV      = 1,
   parameter bit REFRESH_EN = 1'b1,
   parameter int MAX_WAIT   = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_io_i,
   input  logic        cmd_wr_i,
   input  logic [15:0] cmd_addr_i,
   input  logic [7:0]  cmd_data_i,
   output logic        rsp_valid_o,
   output logic [7:0]  rsp_data_o,
   output logic        rsp_err_o,
   output logic [15:0] a_o,
   output logic [7:0]  d_o,
   output logic        d_oe_o,
   input  logic [7:0]  d_i,
   input  logic        wait_n_i,
   output logic        mreq_n_o,
   output logic        iorq_n_o,
   output logic        rd_n_o,
   output logic        wr_n_o,
   output logic        rfsh_n_o
);

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_R1, S_R2} state_t;

   localparam logic [3:0] TC_LOAD    = 4'(T_DIV - 1);
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_t      state, state_nxt;
   logic [3:0]  tcnt, tcnt_nxt;
   logic [7:0]  wcnt, wcnt_nxt;
   logic [6:0]  rcnt, rcnt_nxt;
   logic        cmd_io, cmd_wr;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_data;
   logic        accept, tlast, abort;

   logic        eff_io, eff_wr;
   logic [15:0] eff_addr;
   logic [7:0]  eff_data;
   logic        mreq_nxt, iorq_nxt, rd_nxt, wr_nxt, rfsh_nxt, doe_nxt;
   logic [15:0] a_nxt;
   logic [7:0]  d_nxt, rsp_data_nxt;
   logic        rsp_valid_nxt, rsp_err_nxt, ready_nxt;

   // Next-state: T-state down-counter, wait counting and abort decision
   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      wcnt_nxt  = wcnt;
      rcnt_nxt  = rcnt;
      abort     = 1'b0;
      accept    = cmd_valid_i & cmd_ready_o;
      tlast     = (tcnt == 4'd0);
      if (state == S_IDLE) begin
         if (accept) begin
            state_nxt = S_T1;
            tcnt_nxt  = TC_LOAD;
            wcnt_nxt  = 8'd0;
         end
      end else if (!tlast) begin
         tcnt_nxt = tcnt - 4'd1;
      end else begin
         tcnt_nxt = TC_LOAD;
         case (state)
            S_T1: state_nxt = S_T2;
            S_T2: begin
               // I/O cycles always take one TW; it counts toward the limit
               if (cmd_io || !wait_n_i) begin
                  state_nxt = S_TW;
                  wcnt_nxt  = 8'd1;
               end else begin
                  state_nxt = S_T3;
               end
            end
            S_TW: begin
               if (wait_n_i) begin
                  state_nxt = S_T3;
               end else if (wcnt >= WAIT_LIMIT) begin
                  state_nxt = S_IDLE;
                  abort     = 1'b1;
               end else begin
                  wcnt_nxt = wcnt + 8'd1;
               end
            end
            S_T3: state_nxt = (!cmd_io && REFRESH_EN) ? S_R1 : S_IDLE;
            S_R1: state_nxt = S_R2;
            S_R2: begin
               state_nxt = S_IDLE;
               rcnt_nxt  = rcnt + 7'd1;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Output decode from the next state so every bus output comes straight from a flop
   always_comb begin
      eff_io        = accept ? cmd_io_i   : cmd_io;
      eff_wr        = accept ? cmd_wr_i   : cmd_wr;
      eff_addr      = accept ? cmd_addr_i : cmd_addr;
      eff_data      = accept ? cmd_data_i : cmd_data;
      mreq_nxt      = 1'b1;
      iorq_nxt      = 1'b1;
      rd_nxt        = 1'b1;
      wr_nxt        = 1'b1;
      rfsh_nxt      = 1'b1;
      doe_nxt       = 1'b0;
      a_nxt         = a_o;
      d_nxt         = d_o;
      rsp_valid_nxt = 1'b0;
      rsp_err_nxt   = 1'b0;
      rsp_data_nxt  = rsp_data_o;
      ready_nxt     = (state_nxt == S_IDLE);
      if (state == S_T3 && tlast && !cmd_wr) begin
         rsp_data_nxt = d_i;
      end
      case (state_nxt)
         S_T1, S_T2, S_TW, S_T3: begin
            a_nxt = eff_addr;
            if (eff_wr) begin
               d_nxt   = eff_data;
               doe_nxt = 1'b1;
            end
            if (!eff_io) begin
               mreq_nxt = 1'b0;
               rd_nxt   = eff_wr;
               if (state_nxt != S_T1) wr_nxt = !eff_wr;
            end else if (state_nxt != S_T1) begin
               iorq_nxt = 1'b0;
               rd_nxt   = eff_wr;
               wr_nxt   = !eff_wr;
            end
         end
         S_R1: begin
            a_nxt    = {9'b0, rcnt};
            rfsh_nxt = 1'b0;
         end
         S_R2: begin
            rfsh_nxt = 1'b0;
            mreq_nxt = 1'b0;
         end
         default: begin
            if (state != S_IDLE) begin
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = abort;
            end
         end
      endcase
   end

   // State, counters and command latch
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= S_IDLE;
         tcnt     <= 4'd0;
         wcnt     <= 8'd0;
         rcnt     <= 7'd0;
         cmd_io   <= 1'b0;
         cmd_wr   <= 1'b0;
         cmd_addr <= 16'h0000;
         cmd_data <= 8'h00;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
         wcnt  <= wcnt_nxt;
         rcnt  <= rcnt_nxt;
         if (accept) begin
            cmd_io   <= cmd_io_i;
            cmd_wr   <= cmd_wr_i;
            cmd_addr <= cmd_addr_i;
            cmd_data <= cmd_data_i;
         end
      end
   end

   // Registered bus and response outputs
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mreq_n_o    <= 1'b1;
         iorq_n_o    <= 1'b1;
         rd_n_o      <= 1'b1;
         wr_n_o      <= 1'b1;
         rfsh_n_o    <= 1'b1;
         d_oe_o      <= 1'b0;
         a_o         <= 16'h0000;
         d_o         <= 8'h00;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_data_o  <= 8'h00;
         cmd_ready_o <= 1'b1;
      end else begin
         mreq_n_o    <= mreq_nxt;
         iorq_n_o    <= iorq_nxt;
         rd_n_o      <= rd_nxt;
         wr_n_o      <= wr_nxt;
         rfsh_n_o    <= rfsh_nxt;
         d_oe_o      <= doe_nxt;
         a_o         <= a_nxt;
         d_o         <= d_nxt;
         rsp_valid_o <= rsp_valid_nxt;
         rsp_err_o   <= rsp_err_nxt;
         rsp_data_o  <= rsp_data_nxt;
         cmd_ready_o <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_cv_bus_initiator.sv
// Bench for cv_bus_initiator: two instances (T_DIV=1/MAX_WAIT=8 and
// T_DIV=3/MAX_WAIT=4), a phase-list reference model, a vector table,
// reset/back-to-back sequences and randomized commands.
module tb_cv_bus_initiator;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        cmd_valid, cmd_io, cmd_wr, wait_n, sel;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_data, d_in;

   logic        rdy1, rv1, err1, doe1, mreq1, iorq1, rd1, wr1, rfsh1;
   logic [7:0]  rdat1, d1;
   logic [15:0] a1;
   logic        rdy3, rv3, err3, doe3, mreq3, iorq3, rd3, wr3, rfsh3;
   logic [7:0]  rdat3, d3;
   logic [15:0] a3;

   logic        valid1, valid3;
   assign valid1 = cmd_valid & ~sel;
   assign valid3 = cmd_valid & sel;

   cv_bus_initiator #(.T_DIV(1), .REFRESH_EN(1'b1), .MAX_WAIT(8)) u_dut1 (
      .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(valid1), .cmd_ready_o(rdy1),
      .cmd_io_i(cmd_io), .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
      .rsp_valid_o(rv1), .rsp_data_o(rdat1), .rsp_err_o(err1), .a_o(a1), .d_o(d1),
      .d_oe_o(doe1), .d_i(d_in), .wait_n_i(wait_n), .mreq_n_o(mreq1), .iorq_n_o(iorq1),
      .rd_n_o(rd1), .wr_n_o(wr1), .rfsh_n_o(rfsh1));

   cv_bus_initiator #(.T_DIV(3), .REFRESH_EN(1'b1), .MAX_WAIT(4)) u_dut3 (
      .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(valid3), .cmd_ready_o(rdy3),
      .cmd_io_i(cmd_io), .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
      .rsp_valid_o(rv3), .rsp_data_o(rdat3), .rsp_err_o(err3), .a_o(a3), .d_o(d3),
      .d_oe_o(doe3), .d_i(d_in), .wait_n_i(wait_n), .mreq_n_o(mreq3), .iorq_n_o(iorq3),
      .rd_n_o(rd3), .wr_n_o(wr3), .rfsh_n_o(rfsh3));

   always #5 clk = ~clk;

   // {mreq, iorq, rd, wr, rfsh, d_oe, rsp_valid, cmd_ready}
   wire [7:0]  st1 = {mreq1, iorq1, rd1, wr1, rfsh1, doe1, rv1, rdy1};
   wire [7:0]  st3 = {mreq3, iorq3, rd3, wr3, rfsh3, doe3, rv3, rdy3};
   wire [7:0]  o_st    = sel ? st3   : st1;
   wire [15:0] o_a     = sel ? a3    : a1;
   wire [7:0]  o_d     = sel ? d3    : d1;
   wire        o_err   = sel ? err3  : err1;
   wire [7:0]  o_rdata = sel ? rdat3 : rdat1;

   localparam logic [7:0] ST_IDLE = 8'b1111_1001;
   localparam logic [7:0] ST_RSP  = 8'b1111_1011;

   int n_chk = 0;
   int n_pass = 0;

   logic [6:0]  rcnt_m [2];
   logic [7:0]  rdata_m[2];
   logic [15:0] a_m    [2];
   bit          a_ok   [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int j = 0; j < 2; j++) begin
         rcnt_m[j] = 7'd0; rdata_m[j] = 8'h00; a_m[j] = 16'h0000; a_ok[j] = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_bus", o_st, ST_IDLE);
         if (a_ok[sel]) chk("idle_addr", o_a, a_m[sel]);
      end
   endtask

   // Drive one command from a negedge and check every clock until its response.
   // Phases: 0=T1 1=T2 2=TW 3=T3 4=R1 5=R2, each lasting tdiv clocks.
   task automatic run_cmd(input bit s, input bit io, input bit wr, input logic [15:0] addr,
                          input logic [7:0] data, input int nw, input logic [7:0] din,
                          output int lat, output logic err, output logic [7:0] rdata);
      int ph[$];
      int tdiv, mw, ntw, low_until, len, pi, p;
      bit abort, refr;
      logic m, i, r, w, f, oe, ca;
      logic [15:0] ea;
      tdiv = s ? 3 : 1;
      mw   = s ? 4 : 8;
      if (!io) begin ntw = nw;     low_until = (nw > 0) ? nw     : -1; end
      else     begin ntw = nw + 1; low_until = (nw > 0) ? nw + 1 : -1; end
      abort = (ntw > mw);
      if (abort) ntw = mw;
      refr = !io && !abort;
      ph.push_back(0); ph.push_back(1);
      for (int j = 0; j < ntw; j++) ph.push_back(2);
      if (!abort) ph.push_back(3);
      if (refr) begin ph.push_back(4); ph.push_back(5); end
      len = ph.size() * tdiv + 1;
      sel = s; cmd_valid = 1'b1; cmd_io = io; cmd_wr = wr;
      cmd_addr = addr; cmd_data = data; d_in = din; wait_n = 1'b1;
      lat = 0; err = 1'b0; rdata = 8'h00;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (o_st[1] && lat == 0) lat = k;
         if (k < len) begin
            cmd_valid = 1'($urandom); cmd_io = 1'($urandom); cmd_wr = 1'($urandom);
            cmd_addr = 16'($urandom); cmd_data = 8'($urandom);
            pi = (k - 1) / tdiv;
            p = ph[pi];
            wait_n = (pi > low_until);
            m = 1; i = 1; r = 1; w = 1; f = 1; oe = 0; ca = 1; ea = addr;
            case (p)
               0: begin oe = wr; if (!io) begin m = 0; r = wr; end end
               1, 2, 3: begin
                  oe = wr; r = wr; w = !wr;
                  if (!io) m = 0; else i = 0;
               end
               4: begin f = 0; ea = {9'b0, rcnt_m[s]}; end
               default: begin f = 0; m = 0; ca = 0; end
            endcase
            chk("bus", o_st, {m, i, r, w, f, oe, 1'b0, 1'b0});
            if (ca) chk("addr", o_a, ea);
            if (oe) chk("dout", o_d, data);
         end else begin
            cmd_valid = 1'b0; wait_n = 1'b1;
            if (refr) rcnt_m[s] = rcnt_m[s] + 7'd1;
            if (!abort && !wr) rdata_m[s] = din;
            chk("rsp_bus", o_st, ST_RSP);
            chk("rsp_err", o_err, abort);
            chk("rsp_data", o_rdata, rdata_m[s]);
            if (refr) a_ok[s] = 1'b0;
            else begin
               chk("rsp_addr", o_a, addr);
               a_m[s] = addr; a_ok[s] = 1'b1;
            end
            err = o_err; rdata = o_rdata;
         end
      end
   endtask

   typedef struct {
      bit s; bit io; bit wr; logic [15:0] addr; logic [7:0] data; int nw; logic [7:0] din;
      int lat; bit err; logic [7:0] rdata;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic err;
      logic [7:0] rd;
      tbl[0]  = '{0, 0, 1, 16'h2000, 8'hA5, 0,   8'h00, 6,  0, 8'h00};
      tbl[1]  = '{0, 1, 1, 16'h007F, 8'h0F, 0,   8'h00, 5,  0, 8'h00};
      tbl[2]  = '{0, 0, 0, 16'h8000, 8'h00, 2,   8'h3C, 8,  0, 8'h3C};
      tbl[3]  = '{0, 0, 0, 16'h8001, 8'h00, 255, 8'hC3, 11, 1, 8'h3C};
      tbl[4]  = '{0, 1, 0, 16'h0042, 8'h00, 1,   8'h5A, 6,  0, 8'h5A};
      tbl[5]  = '{0, 1, 0, 16'h0043, 8'h00, 200, 8'h11, 11, 1, 8'h5A};
      tbl[6]  = '{0, 1, 0, 16'h00FF, 8'h00, 7,   8'h42, 12, 0, 8'h42};
      tbl[7]  = '{0, 0, 0, 16'h0100, 8'h00, 8,   8'h24, 14, 0, 8'h24};
      tbl[8]  = '{1, 0, 1, 16'h1234, 8'h77, 0,   8'h00, 16, 0, 8'h00};
      tbl[9]  = '{1, 0, 0, 16'h4321, 8'h00, 1,   8'h99, 19, 0, 8'h99};
      tbl[10] = '{1, 0, 0, 16'h4322, 8'h00, 50,  8'hEE, 19, 1, 8'h99};

      reset_i = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_io = 1'b0; cmd_wr = 1'b0;
      cmd_addr = 16'h0; cmd_data = 8'h0; d_in = 8'h0; wait_n = 1'b1;
      model_reset();
      #1;
      chk("reset_st1", st1, ST_IDLE);
      chk("reset_st3", st3, ST_IDLE);
      chk("reset_a", a1, 16'h0000);
      chk("reset_d", d1, 8'h00);
      chk("reset_rdata", rdat1, 8'h00);
      chk("reset_err", err1, 1'b0);
      @(negedge clk);
      reset_i = 1'b0;
      idle(2);

      for (int n = 0; n < 11; n++) begin
         run_cmd(tbl[n].s, tbl[n].io, tbl[n].wr, tbl[n].addr, tbl[n].data, tbl[n].nw,
                 tbl[n].din, lat, err, rd);
         chk($sformatf("tbl%0d_lat", n), lat, tbl[n].lat);
         chk($sformatf("tbl%0d_err", n), err, tbl[n].err);
         chk($sformatf("tbl%0d_rdata", n), rd, tbl[n].rdata);
         idle(2);
      end

      // reset asserted between edges during the second TW of a memory read
      sel = 1'b0; cmd_valid = 1'b1; cmd_io = 1'b0; cmd_wr = 1'b0;
      cmd_addr = 16'h8000; wait_n = 1'b0;
      @(negedge clk); cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_rd", rd1, 1'b0);
      chk("pre_rst_mreq", mreq1, 1'b0);
      #2 reset_i = 1'b1;
      #1;
      chk("rst_bus", st1, ST_IDLE);
      chk("rst_addr", a1, 16'h0000);
      chk("rst_rdata", rdat1, 8'h00);
      @(negedge clk);
      reset_i = 1'b0; wait_n = 1'b1;
      model_reset();
      idle(6);

      // back-to-back reads: refresh addresses 0x00..0x7F then 0x00, 0x01
      for (int n = 0; n < 130; n++)
         run_cmd(1'b0, 1'b0, 1'b0, 16'(n * 3), 8'h00, 0, 8'(n), lat, err, rd);
      idle(1);

      for (int n = 0; n < 60; n++) begin
         bit s, io, wr;
         int nw;
         s  = ($urandom_range(0, 4) == 0);
         io = 1'($urandom);
         wr = 1'($urandom);
         nw = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3);
         run_cmd(s, io, wr, 16'($urandom), 8'($urandom), nw, 8'($urandom), lat, err, rd);
         if (1'($urandom)) idle(1);
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cv_bus_initiator.md
Name: cv_bus_initiator

Overview:
- Z80-style bus master. Turns single-beat commands (memory/I-O, read/write) into mreq_n/iorq_n/rd_n/wr_n/rfsh_n cycles with correct T-state sequencing.
- Sits on the CPU-side bus that the address decoder and memory-map registers listen to.
- Used by the ADAM net/loader path to poke memory and ports (e.g. the 0x7F memory-map port) without the T80.
- Generates refresh cycles and honours wait_n.

Parameters:
T_DIV, 1, clk_i cycles per T-state (1..16); every strobe edge falls on a T-state boundary
REFRESH_EN, 1, 1 = append two refresh T-states (R1, R2) after every memory cycle
MAX_WAIT, 64, TW states tolerated before abort (1..255)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous reset, active high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high only in IDLE; command accepted when valid&ready
cmd_io_i  in  1  1 = I/O cycle, 0 = memory cycle
cmd_wr_i  in  1  1 = write, 0 = read
cmd_addr_i  in  16  address
cmd_data_i  in  8  write data
rsp_valid_o  out  1  one-clock pulse, cycle complete
rsp_data_o  out  8  read data (held until next rsp)
rsp_err_o  out  1  valid with rsp_valid_o; 1 = wait timeout abort
a_o  out  16  bus address
d_o  out  8  bus write data
d_oe_o  out  1  write data drive enable
d_i  in  8  bus read data
wait_n_i  in  1  wait request, active low
mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o  out  1 each  bus strobes, active low

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - All strobes 1; d_oe_o 0; a_o, d_o, rsp_data_o 0x00/0x0000.
  - rsp_valid_o 0, rsp_err_o 0; refresh counter 0; cmd_ready_o 1.
- Command capture: on the clock where cmd_valid_i & cmd_ready_o, latch io/wr/addr/data. State becomes T1 next clock; cmd_ready_o drops with it. No pipelining.
- States: IDLE, T1, T2, TW, T3, R1, R2. Each non-IDLE state lasts T_DIV clocks, counted by a T-state counter.
- Memory cycle:
  - T1..T3: a_o = addr; mreq_n_o 0.
  - Read: rd_n_o 0 in T1..T3.
  - Write: d_o = data and d_oe_o 1 in T1..T3; wr_n_o 0 in T2..T3.
- I/O cycle:
  - Sequence T1, T2, one mandatory TW, T3; a_o = addr throughout.
  - iorq_n_o 0 in T2, TW, T3; rd_n_o or wr_n_o 0 in the same states.
  - Write: d_oe_o 1 from T1.
  - mreq_n_o stays 1.
- Wait handling:
  - wait_n_i is sampled on the last clock of T2 (memory) or of each TW (I/O, including the mandatory one).
  - Memory cycle: low -> enter TW. TW repeats while the sample is low; high -> T3.
  - Wait counter counts TW states. If it reaches MAX_WAIT with wait_n_i still low: release all strobes and d_oe_o on the next clock, skip T3 and refresh, go to IDLE, pulse rsp_valid_o with rsp_err_o 1. rsp_data_o is unchanged.
- Read data: d_i is captured into rsp_data_o on the last clock of T3.
- Completion: rsp_valid_o pulses for one clock, on the first clock after the last bus state (T3, or R2 when refresh runs). cmd_ready_o is 1 in that same clock.
- Refresh:
  - Runs only after a successful memory cycle, and only if REFRESH_EN.
  - R1: a_o = {9'b0, rcnt[6:0]}; rfsh_n_o 0; mreq_n_o 1.
  - R2: rfsh_n_o 0; mreq_n_o 0; rd_n_o/wr_n_o 1; d_oe_o 0.
  - rcnt increments at the end of R2 and wraps 0x7F -> 0x00.
  - Never runs after I/O cycles or after an abort.
- Outputs are registered; strobes must be glitch-free.
- Between cycles (IDLE): strobes 1, d_oe_o 0, a_o holds its last value.
- cmd_valid_i while busy: ignored, no effect.
- Reset in any state: immediate release; any in-flight command is dropped and no rsp is issued.

Test Plan:
- Memory write, T_DIV=1, REFRESH_EN=1, addr 0x2000, data 0xA5, wait_n 1 -> mreq_n_o low 3 clocks, wr_n_o low last 2, d_o 0xA5. Then R1/R2 with a_o 0x0000, rfsh_n_o low 2 clocks, mreq_n_o low in R2 only. rsp_valid_o 1 on clock 6 after accept, err 0.
- I/O write port 0x007F, data 0x0F -> iorq_n_o and wr_n_o low 3 clocks (T2, TW, T3), mreq_n_o stays 1, no refresh, rsp_valid_o on clock 5.
- Memory read 0x8000, wait_n_i low for 2 samples, d_i 0x3C in T3 -> two TW inserted, rd_n_o low 5 clocks, rsp_data_o 0x3C, err 0.
- Memory read with MAX_WAIT=8, wait_n_i stuck low -> exactly 8 TW states, strobes released, rsp_err_o 1, rsp_data_o unchanged, no refresh.
- 130 back-to-back memory reads -> refresh a_o runs 0x00..0x7F, then 0x00, 0x01.
- T_DIV=3 memory write -> every strobe edge lands on a 3-clock boundary; mreq_n_o low 9 clocks.
- reset_i asserted mid-TW -> all strobes 1 and d_oe_o 0 without a clock edge; no rsp_valid_o; cmd_ready_o 1 after release.
